// File: rtl/ether_pkg.sv
// ether_pkg: constants and types shared by the Ethernet MAC blocks.
//   RMII preamble/SFD dibits, CRC-32 (reflected) constants, frame size
//   limits, broadcast address, receive FSM state encoding and a helper that
//   picks one byte of a MAC address in wire order.
package ether_pkg;

    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_DIBIT      = 2'b11;

    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY       = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;

    localparam int          BYTE_CNT_W     = 11;
    localparam logic [10:0] MIN_FRAME      = 11'd64;
    localparam logic [10:0] MAX_FRAME      = 11'd1518;
    localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_FRAME,
        ST_DROP
    } rx_state_t;

    // Byte idx (0 = first on the wire) of a MAC address whose first wire
    // byte is the MSB.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac,
                                            input logic [2:0]  idx);
        logic [47:0] v_s;
        v_s = mac << (6'd8 * idx);
        return v_s[47:40];
    endfunction

endpackage

// File: rtl/crc32_dibit.sv
// crc32_dibit: combinational CRC-32 (reflected, poly 0xEDB88320) advance by
// one RMII dibit. i_dibit[0] is the earlier bit on the wire.
//   i_crc   [31:0]  current CRC register
//   i_dibit [1:0]   received dibit
//   o_crc   [31:0]  CRC register after both bits
module crc32_dibit
    import ether_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [1:0]  i_dibit,
    output logic [31:0] o_crc
);

    logic [31:0] w_c1;

    always_comb begin
        w_c1  = {1'b0, i_crc[31:1]} ^ ((i_crc[0] ^ i_dibit[0]) ? CRC_POLY : 32'h0);
        o_crc = {1'b0, w_c1[31:1]}  ^ ((w_c1[0]  ^ i_dibit[1]) ? CRC_POLY : 32'h0);
    end

endmodule

// File: rtl/rmii_frame_rx.sv
// rmii_frame_rx: RMII receive MAC front end. Strips preamble/SFD, filters on
// destination MAC (own unicast or broadcast), checks byte alignment, length
// and FCS, and publishes the EtherType and first 32 payload bits of each
// accepted frame with a one-cycle valid pulse.
//   i_clk        50 MHz RMII reference clock
//   i_rst        synchronous active-high reset
//   i_crsdv      RMII carrier-sense / data-valid
//   i_rxd[1:0]   RMII dibit, bit 0 earlier
//   o_ethertype  EtherType of last accepted frame
//   o_data       first 4 payload bytes of last accepted frame
//   o_valid      one-cycle pulse per accepted frame
module rmii_frame_rx
    import ether_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC = 48'h69_69_5A_06_54_91
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_crsdv,
    input  logic [1:0]  i_rxd,
    output logic [15:0] o_ethertype,
    output logic [31:0] o_data,
    output logic        o_valid
);

    rx_state_t              r_state, w_next;
    logic [31:0]            r_crc;
    logic [31:0]            w_crc_nxt;
    logic [1:0]             r_dcnt;
    logic [5:0]             r_sh;       // three earlier dibits of current byte
    logic [BYTE_CNT_W-1:0]  r_bcnt;
    logic                   r_uc_ok;    // dest bytes so far match FPGA_MAC
    logic                   r_bc_ok;    // dest bytes so far match broadcast
    logic [15:0]            r_et_sh;
    logic [31:0]            r_data_sh;
    logic [15:0]            r_ethertype;
    logic [31:0]            r_data;
    logic                   r_valid;

    logic [7:0]             w_byte;
    logic                   w_byte_done;
    logic                   w_in_dst;
    logic                   w_uc_hit;
    logic                   w_bc_hit;
    logic                   w_len_ok;
    logic                   w_accept;
    logic [BYTE_CNT_W-1:0]  w_bcnt_inc;

    crc32_dibit u_crc (
        .i_crc   (r_crc),
        .i_dibit (i_rxd),
        .o_crc   (w_crc_nxt)
    );

    assign w_byte      = {i_rxd, r_sh};
    assign w_byte_done = (r_state == ST_FRAME) && i_crsdv && (r_dcnt == 2'd3);
    assign w_in_dst    = (r_bcnt < 11'd6);
    assign w_uc_hit    = r_uc_ok && (w_byte == mac_byte(FPGA_MAC, r_bcnt[2:0]));
    assign w_bc_hit    = r_bc_ok && (w_byte == mac_byte(BROADCAST_MAC, r_bcnt[2:0]));
    assign w_len_ok    = (r_bcnt >= MIN_FRAME) && (r_bcnt <= MAX_FRAME);
    assign w_bcnt_inc  = (&r_bcnt) ? r_bcnt : r_bcnt + 11'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            // IDLE evaluates the first carrier dibit exactly like PREAMBLE.
            ST_IDLE, ST_PREAMBLE: begin
                if (!i_crsdv)                     w_next = ST_IDLE;
                else if (i_rxd == PREAMBLE_DIBIT) w_next = ST_PREAMBLE;
                else if (i_rxd == SFD_DIBIT)      w_next = ST_FRAME;
                else                              w_next = ST_DROP;
            end
            ST_FRAME: begin
                if (!i_crsdv) begin
                    w_next   = ST_IDLE;
                    w_accept = (r_dcnt == 2'd0) && w_len_ok && (r_crc == CRC_RESIDUE);
                end else if (w_byte_done && w_in_dst && !w_uc_hit && !w_bc_hit) begin
                    w_next = ST_DROP;
                end else if (w_byte_done && (r_bcnt >= MAX_FRAME)) begin
                    // this byte takes the count past the maximum
                    w_next = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!i_crsdv) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_crc       <= CRC_INIT;
            r_dcnt      <= 2'd0;
            r_sh        <= 6'd0;
            r_bcnt      <= '0;
            r_uc_ok     <= 1'b1;
            r_bc_ok     <= 1'b1;
            r_et_sh     <= 16'h0;
            r_data_sh   <= 32'h0;
            r_ethertype <= 16'h0;
            r_data      <= 32'h0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_ethertype <= r_et_sh;
                r_data      <= r_data_sh;
            end
            if (r_state == ST_FRAME) begin
                if (i_crsdv) begin
                    r_crc  <= w_crc_nxt;
                    r_dcnt <= r_dcnt + 2'd1;
                    r_sh   <= {i_rxd, r_sh[5:2]};
                    if (r_dcnt == 2'd3) begin
                        r_bcnt <= w_bcnt_inc;
                        if (w_in_dst) begin
                            r_uc_ok <= w_uc_hit;
                            r_bc_ok <= w_bc_hit;
                        end
                        if (r_bcnt == 11'd12 || r_bcnt == 11'd13)
                            r_et_sh <= {r_et_sh[7:0], w_byte};
                        if (r_bcnt >= 11'd14 && r_bcnt <= 11'd17)
                            r_data_sh <= {r_data_sh[23:0], w_byte};
                    end
                end
            end else begin
                // Outside a frame, keep the per-frame state primed so a frame
                // can start after a single idle cycle.
                r_crc   <= CRC_INIT;
                r_dcnt  <= 2'd0;
                r_bcnt  <= '0;
                r_uc_ok <= 1'b1;
                r_bc_ok <= 1'b1;
            end
        end
    end

    assign o_ethertype = r_ethertype;
    assign o_data      = r_data;
    assign o_valid     = r_valid;

endmodule

// File: tb/tb_rmii_frame_rx.sv
module tb_rmii_frame_rx;

    localparam logic [47:0] MY_MAC = 48'h69_69_5A_06_54_91;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crsdv = 1'b0;
    logic [1:0]  rxd = 2'b00;
    logic [15:0] o_ethertype;
    logic [31:0] o_data;
    logic        o_valid;

    int          checks = 0;
    int          errors = 0;
    int          vhigh = 0;      // cycles o_valid observed high
    int          acc_total = 0;  // accepts expected so far
    logic [7:0]  frm[$];
    logic [47:0] sb[$];          // expected {ethertype, data}

    rmii_frame_rx #(.FPGA_MAC(MY_MAC)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_crsdv     (crsdv),
        .i_rxd       (rxd),
        .o_ethertype (o_ethertype),
        .o_data      (o_data),
        .o_valid     (o_valid)
    );

    always #10 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
        if (o_valid) vhigh++;
    endtask

    function automatic logic [31:0] crc_of_frm();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (frm[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[k][b];
                c  = (c >> 1) ^ (fb ? 32'hEDB8_8320 : 32'h0);
            end
        end
        return c;
    endfunction

    // total length includes the 4 FCS bytes
    task automatic build(input logic [47:0] dst, input logic [15:0] et,
                         input logic [31:0] dat, input int len);
        logic [47:0] t;
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < 6; i++) begin
            t = dst >> (8 * (5 - i));
            frm.push_back(t[7:0]);
        end
        for (int i = 0; i < 6; i++) frm.push_back(8'h00);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        frm.push_back(dat[31:24]);
        frm.push_back(dat[23:16]);
        frm.push_back(dat[15:8]);
        frm.push_back(dat[7:0]);
        while (frm.size() < len - 4) frm.push_back(8'(frm.size() * 7));
        fcs = ~crc_of_frm();
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    task automatic check_out(input string tag, input logic [47:0] exp);
        checks++;
        assert ({o_ethertype, o_data} === exp) else begin
            errors++;
            $error("FAIL %s outputs got %h want %h", tag, {o_ethertype, o_data}, exp);
        end
    endtask

    // Sends preamble+SFD+frm, then exactly one crsdv=0 cycle; returns on the
    // negedge where the next frame may start.
    task automatic send(input string tag, input bit exp_acc, input logic [47:0] exp_f,
                        input int trim, input int bad_pre_at, input int rst_byte);
        int         nd;
        logic [7:0] b;
        logic [47:0] f;
        if (exp_acc) begin
            sb.push_back(exp_f);
            acc_total++;
        end
        nd = frm.size() * 4 - trim;
        for (int i = 0; i < 32; i++) begin
            crsdv = 1'b1;
            rxd   = (i == 31) ? 2'b11 : ((i == bad_pre_at) ? 2'b10 : 2'b01);
            tick();
        end
        for (int i = 0; i < nd; i++) begin
            b   = frm[i / 4];
            rxd = b[2 * (i % 4) +: 2];
            rst = (i == rst_byte * 4);
            tick();
        end
        rst   = 1'b0;
        crsdv = 1'b0;
        rxd   = 2'b00;
        tick();
        checks++;
        assert (o_valid === exp_acc) else begin
            errors++;
            $error("FAIL %s valid got %0b want %0b", tag, o_valid, exp_acc);
        end
        if (o_valid) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL %s unexpected valid got queue %0d want >0", tag, sb.size());
            end
            if (sb.size() > 0) begin
                f = sb.pop_front();
                check_out(tag, f);
            end
        end
        checks++;
        assert (vhigh === acc_total) else begin
            errors++;
            $error("FAIL %s valid_cycles got %0d want %0d", tag, vhigh, acc_total);
        end
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        assert (o_valid === 1'b0) else begin
            errors++;
            $error("FAIL reset_valid got %0b want 0", o_valid);
        end
        check_out("reset_out", 48'h0);

        // bad FCS first: outputs must stay at reset values
        build(MY_MAC, 16'h0004, 32'h1234_5678, 64);
        frm[63] = frm[63] ^ 8'h01;
        send("bad_fcs", 1'b0, 48'h0, 0, -1, -1);
        check_out("bad_fcs_hold", 48'h0);
        repeat (3) tick();

        build(MY_MAC, 16'h0004, 32'h1234_5678, 64);
        send("good_uc", 1'b1, {16'h0004, 32'h1234_5678}, 0, -1, -1);
        repeat (2) tick();

        build(48'h02_00_00_00_00_01, 16'h0009, 32'h0BAD_0BAD, 64);
        send("wrong_dst", 1'b0, 48'h0, 0, -1, -1);
        check_out("wrong_dst_hold", {16'h0004, 32'h1234_5678});

        build(48'hFF_FF_FF_FF_FF_FF, 16'h0002, 32'hDEAD_BEEF, 64);
        send("bcast", 1'b1, {16'h0002, 32'hDEAD_BEEF}, 0, -1, -1);

        build(MY_MAC, 16'h0005, 32'h5555_AAAA, 60);
        send("runt", 1'b0, 48'h0, 0, -1, -1);

        build(MY_MAC, 16'h0006, 32'h6666_0000, 1519);
        send("oversize", 1'b0, 48'h0, 0, -1, -1);

        build(MY_MAC, 16'h0007, 32'h7777_1111, 1518);
        send("max_len", 1'b1, {16'h0007, 32'h7777_1111}, 0, -1, -1);

        build(MY_MAC, 16'h0008, 32'h8888_2222, 64);
        send("odd_dibit", 1'b0, 48'h0, 1, -1, -1);
        check_out("odd_dibit_hold", {16'h0007, 32'h7777_1111});
        repeat (2) tick();

        // preamble fault, then good frames with the minimum one-cycle gap
        build(MY_MAC, 16'h0009, 32'h9999_3333, 64);
        send("bad_pre", 1'b0, 48'h0, 0, 10, -1);
        build(MY_MAC, 16'h0003, 32'hCAFE_F00D, 64);
        send("after_bad_pre", 1'b1, {16'h0003, 32'hCAFE_F00D}, 0, -1, -1);
        build(48'hFF_FF_FF_FF_FF_FF, 16'h000A, 32'h0102_0304, 80);
        send("back_to_back", 1'b1, {16'h000A, 32'h0102_0304}, 0, -1, -1);
        repeat (2) tick();

        // reset in the middle of a good frame
        build(MY_MAC, 16'h000B, 32'hABCD_EF01, 64);
        send("rst_mid", 1'b0, 48'h0, 0, -1, 10);
        check_out("rst_mid_out", 48'h0);
        build(MY_MAC, 16'h000C, 32'h1357_9BDF, 64);
        send("after_rst", 1'b1, {16'h000C, 32'h1357_9BDF}, 0, -1, -1);

        repeat (5) tick();
        checks++;
        assert (vhigh === acc_total && sb.size() == 0) else begin
            errors++;
            $error("FAIL final valid_cycles got %0d/%0d left want %0d/0",
                   vhigh, sb.size(), acc_total);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
